// File: rtl/led_cube_frame_buffer.sv
// led_cube_frame_buffer
// Purpose : double-buffered 4x4x4 LED frame store with tear-free swap and a
//           layer-multiplexed PWM scanner driving one-hot layer enables and
//           16 column drives.
// Ports   : clk, rst_n (sync, active-low)
//           wr_valid/wr_data/wr_index : indexed brightness bytes into the back
//                                       buffer (never stalled)
//           display_en                : 1 drives outputs, 0 blanks them
//           layer_en/col_out          : registered cube drive, 1-cycle latency
//           frame_swapped             : 1-cycle pulse after front is reloaded
//           swap_pending              : complete frame waiting in back buffer
module led_cube_frame_buffer #(
  parameter int PWM_DIV  = 4,
  parameter int N_LAYERS = 4,
  parameter int N_COLS   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  input  logic [7:0]  wr_data,
  input  logic [5:0]  wr_index,
  input  logic        display_en,
  output logic [3:0]  layer_en,
  output logic [15:0] col_out,
  output logic        frame_swapped,
  output logic        swap_pending
);

  localparam int              N_LEDS     = N_LAYERS * N_COLS;
  // A one-bit prescaler is kept for PWM_DIV==1; it simply sits at zero and
  // every cycle is a tick.
  localparam int              PS_W       = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST    = PS_W'(PWM_DIV - 1);
  // 255 PWM slots (0..254) so that brightness 255 is lit in every slot and
  // brightness 0 in none.
  localparam logic [7:0]      PWM_LAST   = 8'd254;
  localparam logic [1:0]      LAYER_LAST = 2'(N_LAYERS - 1);
  localparam logic [5:0]      IDX_LAST   = 6'(N_LEDS - 1);

  // Frame storage
  logic [7:0]      r_back  [N_LEDS];
  logic [7:0]      r_front [N_LEDS];
  logic            r_pending;
  logic            r_swapped;

  // Scan timing
  logic [PS_W-1:0] r_presc;
  logic [7:0]      r_pwm;
  logic [1:0]      r_layer;

  // Output registers
  logic [3:0]      r_layer_en;
  logic [15:0]     r_col;

  logic            w_tick;
  logic            w_pwm_last;
  logic            w_boundary;
  logic            w_wr_last;
  logic            w_swap;
  logic [15:0]     w_col_nxt;
  logic [3:0]      w_layer_oh;

  assign w_tick     = (r_presc == PS_LAST);
  assign w_pwm_last = (r_pwm == PWM_LAST);
  // Last cycle of the last PWM slot of the top layer: the only point where the
  // front buffer may change, so a scan never shows two different frames.
  assign w_boundary = w_tick && w_pwm_last && (r_layer == LAYER_LAST);
  assign w_wr_last  = wr_valid && (wr_index == IDX_LAST);
  assign w_swap     = w_boundary && r_pending;

  // ---------------------------------------------------------------------------
  // Prescaler, PWM slot counter and layer counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_pwm   <= '0;
      r_layer <= '0;
    end else begin
      if (w_tick) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + 1'b1;
      end

      if (w_tick) begin
        if (w_pwm_last) begin
          r_pwm <= '0;
          if (r_layer == LAYER_LAST) begin
            r_layer <= '0;
          end else begin
            r_layer <= r_layer + 1'b1;
          end
        end else begin
          r_pwm <= r_pwm + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Back/front buffers. The copy uses the back contents from before this edge,
  // so a write landing on the swap cycle belongs to the next frame.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_LEDS; i++) begin
        r_back[i]  <= '0;
        r_front[i] <= '0;
      end
    end else begin
      if (w_swap) begin
        for (int i = 0; i < N_LEDS; i++) begin
          r_front[i] <= r_back[i];
        end
      end
      if (wr_valid) begin
        r_back[wr_index] <= wr_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame-complete flag. A last-index write on the swap cycle re-arms it for
  // the following boundary instead of being lost in the clear.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
      r_swapped <= 1'b0;
    end else begin
      r_swapped <= w_swap;
      if (w_swap) begin
        r_pending <= w_wr_last;
      end else if (w_wr_last) begin
        r_pending <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Cube drive: compare each column of the active layer against the PWM slot.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_col_nxt  = '0;
    w_layer_oh = '0;
    for (int c = 0; c < N_COLS; c++) begin
      w_col_nxt[c] = display_en && (r_front[{r_layer, 4'(c)}] > r_pwm);
    end
    if (display_en) begin
      w_layer_oh[r_layer] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_layer_en <= '0;
      r_col      <= '0;
    end else begin
      r_layer_en <= w_layer_oh;
      r_col      <= w_col_nxt;
    end
  end

  assign layer_en      = r_layer_en;
  assign col_out       = r_col;
  assign frame_swapped = r_swapped;
  assign swap_pending  = r_pending;

endmodule

// File: tb/tb_led_cube_frame_buffer.sv
// Testbench for led_cube_frame_buffer: directed frames with hand-derived
// expectations queued per clock, checked by an independent negedge monitor.
module tb_led_cube_frame_buffer;

  localparam int DIV = 2;            // PWM_DIV under test
  localparam int L   = 255 * DIV;    // layer period in cycles
  localparam int S   = 4 * L;        // full scan period in cycles

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic [5:0]  wr_index;
  logic        display_en;
  logic [3:0]  layer_en;
  logic [15:0] col_out;
  logic        frame_swapped;
  logic        swap_pending;

  led_cube_frame_buffer #(.PWM_DIV(DIV), .N_LAYERS(4), .N_COLS(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_valid      (wr_valid),
    .wr_data       (wr_data),
    .wr_index      (wr_index),
    .display_en    (display_en),
    .layer_en      (layer_en),
    .col_out       (col_out),
    .frame_swapped (frame_swapped),
    .swap_pending  (swap_pending)
  );

  always #5 clk = ~clk;

  // g = number of rising edges so far
  int g = 0;
  always @(posedge clk) g <= g + 1;

  typedef struct {
    int           gc;
    logic [3:0]   le;
    logic [15:0]  col;
    logic         sp;
    logic [127:0] nm;
  } exp_t;

  exp_t oq[$];     // expected output samples, in increasing gc order
  int   sq[$];     // expected frame_swapped pulse times
  int   n_tests = 0;
  int   n_fail  = 0;
  int   gbase   = 0;   // edge count at the last reset edge
  logic done    = 1'b0;

  // PWM duty window measured by the monitor
  int   win_lo  = -1;
  int   win_hi  = -1;
  int   win_exp = 0;
  int   win_cnt = 0;
  int   win_oth = 0;

  function automatic int E(input int e);
    return gbase + e;
  endfunction

  task automatic exp_at(input int gc, input logic [3:0] le, input logic [15:0] col,
                        input logic sp, input logic [127:0] nm);
    exp_t x;
    x.gc = gc; x.le = le; x.col = col; x.sp = sp; x.nm = nm;
    oq.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int gc);
    while (g < gc) step();
  endtask

  task automatic wr(input logic [5:0] idx, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_index = idx;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    exp_t x;
    int   s;
    while (oq.size() > 0 && oq[0].gc <= g) begin
      x = oq.pop_front();
      n_tests++;
      if (x.gc != g) begin
        n_fail++;
        $display("FAIL %0s: sample missed, now g=%0d, required at g=%0d", x.nm, g, x.gc);
      end else if (layer_en !== x.le || col_out !== x.col || swap_pending !== x.sp) begin
        n_fail++;
        $display("FAIL %0s g=%0d: got layer_en=%b col_out=%h swap_pending=%b, required layer_en=%b col_out=%h swap_pending=%b",
                 x.nm, g, layer_en, col_out, swap_pending, x.le, x.col, x.sp);
      end
    end

    if (frame_swapped === 1'b1) begin
      n_tests++;
      if (sq.size() == 0) begin
        n_fail++;
        $display("FAIL swap_pulse: unexpected frame_swapped at g=%0d, required none", g);
      end else begin
        s = sq.pop_front();
        if (s != g) begin
          n_fail++;
          $display("FAIL swap_pulse: frame_swapped at g=%0d, required at g=%0d", g, s);
        end
      end
    end

    if (g >= win_lo && g <= win_hi) begin
      if (col_out[0] === 1'b1) win_cnt++;
      if (col_out[15:1] !== 15'd0) win_oth++;
      if (g == win_hi) begin
        n_tests++;
        if (win_cnt != win_exp) begin
          n_fail++;
          $display("FAIL pwm_duty: col_out[0] lit %0d cycles, required %0d", win_cnt, win_exp);
        end
        n_tests++;
        if (win_oth != 0) begin
          n_fail++;
          $display("FAIL pwm_dark_cols: other columns lit in %0d cycles, required 0", win_oth);
        end
      end
    end

    if (done) begin
      while (oq.size() > 0) begin
        x = oq.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL %0s: never sampled, required at g=%0d", x.nm, x.gc);
      end
      while (sq.size() > 0) begin
        s = sq.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL swap_pulse: no frame_swapped seen, required at g=%0d", s);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; wr_index = 6'd0; display_en = 1'b1;

    // Reset held 3 edges while index-63 strobes toggle
    for (int i = 1; i <= 3; i++) exp_at(i, 4'b0000, 16'h0000, 1'b0, "reset_hold");
    gbase = 3;
    // Full frame of 0xFF; swap at the first scan boundary
    exp_at(E(1),  4'b0001, 16'h0000, 1'b0, "rst_release");
    exp_at(E(63), 4'b0001, 16'h0000, 1'b0, "pend_before63");
    exp_at(E(64), 4'b0001, 16'h0000, 1'b1, "pend_after63");
    exp_at(E(S-1), 4'b1000, 16'h0000, 1'b1, "pre_boundary");
    exp_at(E(S),   4'b1000, 16'h0000, 1'b0, "swap_cycle");
    sq.push_back(E(S));
    for (int j = 0; j < 4; j++) begin
      exp_at(E(S + j*L + 1),   4'(1 << j), 16'hFFFF, 1'b0, "full_layer_start");
      exp_at(E(S + (j+1)*L),   4'(1 << j), 16'hFFFF, 1'b0, "full_layer_end");
    end
    for (int i = 0; i < 3; i++) begin
      wr_valid = ~i[0]; wr_index = 6'd63; wr_data = 8'hFF;
      step();
    end
    wr_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) wr(6'(i), 8'hFF);
    run_to(E(2*S));

    // PWM duty: only LED 0 = 64
    exp_at(E(2*S + 64), 4'b0001, 16'hFFFF, 1'b1, "duty_pending");
    exp_at(E(3*S),      4'b1000, 16'hFFFF, 1'b0, "duty_swap_cycle");
    sq.push_back(E(3*S));
    exp_at(E(3*S + 1),   4'b0001, 16'h0001, 1'b0, "duty_first");
    exp_at(E(3*S + 128), 4'b0001, 16'h0001, 1'b0, "duty_last_lit");
    exp_at(E(3*S + 129), 4'b0001, 16'h0000, 1'b0, "duty_first_dark");
    exp_at(E(3*S + L),   4'b0001, 16'h0000, 1'b0, "duty_layer_end");
    exp_at(E(3*S + L + 1), 4'b0010, 16'h0000, 1'b0, "zero_never_lit");
    win_lo = E(3*S + 1); win_hi = E(3*S + L); win_exp = 64 * DIV;
    wr(6'd0, 8'd64);
    for (int i = 1; i < 64; i++) wr(6'(i), 8'h00);
    run_to(E(3*S + L + 1));

    // Tearing: frame A (0x11) then partial B (0..31 = 0x80) -> mixed front
    sq.push_back(E(4*S));
    exp_at(E(4*S + 1),       4'b0001, 16'hFFFF, 1'b0, "mix_l0_pwm0");
    exp_at(E(4*S + 255),     4'b0001, 16'hFFFF, 1'b0, "mix_l0_pwm127");
    exp_at(E(4*S + 257),     4'b0001, 16'h0000, 1'b0, "mix_l0_pwm128");
    exp_at(E(4*S + 2*L + 33), 4'b0100, 16'hFFFF, 1'b0, "mix_l2_pwm16");
    exp_at(E(4*S + 2*L + 35), 4'b0100, 16'h0000, 1'b0, "mix_l2_pwm17");
    // Index 63 lands exactly on the boundary edge with nothing pending
    exp_at(E(5*S - 1), 4'b1000, 16'h0000, 1'b0, "late63_before");
    exp_at(E(5*S),     4'b1000, 16'h0000, 1'b1, "late63_noswap");
    exp_at(E(5*S + 101), 4'b0001, 16'hFFFF, 1'b1, "late63_old_front");
    sq.push_back(E(6*S));
    exp_at(E(6*S),      4'b1000, 16'h0000, 1'b0, "late63_swap");
    exp_at(E(6*S + 61), 4'b0001, 16'hFFFF, 1'b0, "late63_pwm30");
    exp_at(E(6*S + 101), 4'b0001, 16'h0000, 1'b0, "late63_pwm50");
    run_to(E(3*S + 600));
    for (int i = 0; i < 64; i++) wr(6'(i), 8'h11);
    for (int i = 0; i < 32; i++) wr(6'(i), 8'h80);
    run_to(E(4*S + 2*L + 100));
    for (int i = 0; i < 63; i++) wr(6'(i), 8'h22);
    run_to(E(5*S - 1));
    wr(6'd63, 8'h22);
    run_to(E(6*S + 101));

    // Overrun: X (0x30) then Y (idx*4) before one boundary
    sq.push_back(E(7*S));
    exp_at(E(7*S + L + 201),   4'b0010, 16'hFC00, 1'b0, "overrun_l1_pwm100");
    exp_at(E(7*S + 3*L + 501), 4'b1000, 16'h8000, 1'b0, "overrun_l3_pwm250");
    run_to(E(6*S + 200));
    for (int i = 0; i < 64; i++) wr(6'(i), 8'h30);
    for (int i = 0; i < 64; i++) wr(6'(i), 8'(i * 4));
    run_to(E(7*S + 3*L + 501));

    // display_en off mid-layer 1, back on in layer 2
    exp_at(E(8*S + L + 100),   4'b0010, 16'hFFFF, 1'b0, "disp_on");
    exp_at(E(8*S + L + 101),   4'b0000, 16'h0000, 1'b0, "disp_off_next");
    exp_at(E(8*S + 2*L + 1),   4'b0000, 16'h0000, 1'b0, "disp_off_l2");
    exp_at(E(8*S + 2*L + 50),  4'b0000, 16'h0000, 1'b0, "disp_off_last");
    exp_at(E(8*S + 2*L + 51),  4'b0100, 16'hFFFF, 1'b0, "disp_resume_l2");
    run_to(E(8*S + L + 100));
    display_en = 1'b0;
    run_to(E(8*S + 2*L + 50));
    display_en = 1'b1;

    // Reset mid-scan with a complete frame pending
    exp_at(E(8*S + 2*L + 115), 4'b0100, 16'hFFFF, 1'b1, "pre_reset_pend");
    exp_at(E(8*S + 2*L + 116), 4'b0000, 16'h0000, 1'b0, "midscan_reset");
    exp_at(E(8*S + 2*L + 117), 4'b0000, 16'h0000, 1'b0, "midscan_reset");
    run_to(E(8*S + 2*L + 51));
    for (int i = 0; i < 64; i++) wr(6'(i), 8'hFF);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    gbase = g;
    exp_at(E(1),     4'b0001, 16'h0000, 1'b0, "post_reset_l0");
    exp_at(E(100),   4'b0001, 16'h0000, 1'b0, "post_reset_cleared");
    exp_at(E(S + 1), 4'b0001, 16'h0000, 1'b0, "post_reset_noswap");
    run_to(E(S + 5));
    done = 1'b1;
    repeat (4) @(posedge clk);
    $display("FAIL tb_end: monitor did not close the run");
    $fatal(1);
  end

endmodule

// File: doc/led_cube_frame_buffer.md
# led_cube_frame_buffer

Double-buffered frame store and layer scanner for the 4x4x4 LED cube. Sits directly downstream of the stream controller in mode 3: takes the 64 indexed brightness bytes per frame, assembles them in a back buffer, swaps to the front buffer only at a scan-frame boundary (no tearing), and multiplexes the front buffer onto the cube as one-hot layer enables plus 16 PWM column drives.

## Interface
- PWM_DIV, 4: clk cycles per PWM tick (>=1)
- N_LAYERS, 4: cube layers (fixed; index[5:4] selects layer)
- N_COLS, 16: LEDs per layer (fixed; index[3:0] selects column)
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- wr_valid  in  1  byte strobe from stream controller (readdatavalid qualified by DATA_READ)
- wr_data  in  8  LED brightness, 0 = off, 255 = fully on
- wr_index  in  6  LED index 0..63 (upstream data_counter)
- display_en  in  1  1 = drive outputs; 0 = blank outputs, scanning continues
- layer_en  out  4  one-hot layer enable, registered
- col_out  out  16  column drive for current layer, registered
- frame_swapped  out  1  one-cycle pulse when front buffer is updated
- swap_pending  out  1  complete frame waiting in back buffer

## Operation
- Storage: back[0..63] and front[0..63], 8 bits each, flops.
- Write: wr_valid=1 -> back[wr_index] <= wr_data. No backpressure; every strobe accepted.
- Frame completion: accepted write with wr_index==63 sets pending. Writes continue to land in back while pending (a newer frame overwrites; latest data wins).
- Prescaler: 0..PWM_DIV-1, tick asserted when prescaler==PWM_DIV-1.
- PWM counter pwm_cnt: 0..254, advances on tick, wraps 254->0.
- Layer counter layer: 0..3, advances on tick when pwm_cnt==254, wraps 3->0.
- Scan boundary: tick && pwm_cnt==254 && layer==3.
- Swap: at scan boundary with pending==1 (registered value): front <= back (pre-edge contents), frame_swapped=1 for that cycle, pending cleared unless an index-63 write is accepted in the same cycle (then pending stays 1).
- Index-63 write on scan-boundary cycle while pending==0: no swap this boundary; pending set, swap at next boundary.
- Drive: col_out[c] <= display_en && (front[layer*16+c] > pwm_cnt); layer_en <= display_en ? (1<<layer) : 0. Value v lit for v of 255 ticks; 255 lit for all ticks.
- Column bit c = wr_index[3:0]; layer = wr_index[5:4].

## Timing
- Reset (rst_n=0 at edge): back, front = 0; pending=0; prescaler, pwm_cnt, layer = 0; layer_en=0; col_out=0; frame_swapped=0. Reset mid-frame discards all buffered data.
- Write latency: back updated at edge of wr_valid; visible in front only after a swap.
- Output latency: layer_en/col_out reflect counters and front buffer sampled at previous edge (1 cycle).
- Swap visible on col_out the cycle after frame_swapped (first tick of layer 0).
- Layer period = 255*PWM_DIV cycles; full scan = 1020*PWM_DIV cycles (4080 at default).
- Max swap latency after completion: one full scan period + 1 cycle.
- display_en change affects outputs one cycle later; never resets counters or buffers.
- swap_pending = pending register directly.

## Test plan
- Reset: hold rst_n=0 3 cycles with wr_valid toggling -> layer_en=0, col_out=0, frame_swapped=0, swap_pending=0; after release layer_en=4'b0001 from cycle 2.
- Full frame: write index 0..63 with data=8'hFF, PWM_DIV=1 -> swap_pending=1 after index 63; frame_swapped pulses exactly once at next boundary; afterwards col_out=16'hFFFF every cycle, layer_en cycles 0001->0010->0100->1000 every 255 cycles.
- PWM duty: front[0]=8'd64, rest 0 -> during layer 0, col_out[0]=1 for exactly 64 of 255 cycles, all other bits 0; value 0 never lit.
- No tearing: complete frame A, then write partial frame B (indices 0..31 = 8'h80) before boundary -> swap copies mixed back buffer (documented: latest data wins); then complete frame with index 63 on exact boundary cycle with pending=0 -> no swap at that boundary, frame_swapped one full scan (4080 cycles @PWM_DIV=4) later.
- Overrun: two complete frames written before one boundary -> single frame_swapped pulse, front = second frame.
- display_en=0 mid-layer -> outputs 0 next cycle, layer counter keeps advancing; re-enable resumes on correct layer with no glitch; reset mid-scan returns to layer 0 with buffers cleared.
